// File: rtl/bus_master_port_pkg.sv
// Shared types and constants for the CPU-side bus master port:
// FSM state encoding, error-cause codes and the default timeout limit.
package bus_master_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } bus_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ADR     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_req_t;

endpackage

// File: rtl/bus_master_port_timeout.sv
// Cycle counter for an outstanding strobe; expired_o flags the last allowed
// cycle so the FSM can abort on that same edge. LIMIT=0 never expires.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned TO_W  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = (LIMIT == 0) ? '0 : TO_W'(LIMIT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/bus_master_port.sv
// CPU-side bus initiator: registers one load/store, holds stb until ack,
// and reports address-decode errors or missing acks as a bus-error pulse.
module bus_master_port
  import bus_master_port_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int unsigned TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_ready_o,
  output logic        cpu_err_o,
  output logic        cpu_busy_o,
  output logic [1:0]  err_cause_o,
  output logic [31:0] err_adr_o,
  output logic        master_stb_o,
  output logic        master_we_o,
  output logic [31:0] master_adr_o,
  output logic [31:0] master_dat_o,
  input  logic [31:0] master_dat_i,
  input  logic        master_ack_i,
  input  logic        adr_err_i
);

  bus_state_e  state_q;
  bus_req_t    req_q;
  logic [31:0] rdat_q;
  logic [31:0] err_adr_q;
  logic [1:0]  cause_q;
  logic        stb_q;
  logic        busy_q;
  logic        ready_q;
  logic        err_q;
  logic        expired_s;

  // Counter is held clear while idle, so each request starts from zero.
  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES),
    .TO_W  (TO_W)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == ST_IDLE),
    .en_i      (state_q == ST_REQ),
    .expired_o (expired_s)
  );

  // Transaction FSM with all CPU- and bus-facing outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rdat_q    <= '0;
      err_adr_q <= '0;
      cause_q   <= ERR_NONE;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_i) begin
            req_q   <= '{we: cpu_we_i, adr: cpu_adr_i, dat: cpu_dat_i};
            cause_q <= ERR_NONE;
            stb_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_REQ;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          // Decode error beats ack, ack beats a same-cycle timeout.
          if (adr_err_i) begin
            stb_q     <= 1'b0;
            err_q     <= 1'b1;
            cause_q   <= ERR_ADR;
            err_adr_q <= req_q.adr;
            state_q   <= ST_ERR;
          end else if (master_ack_i) begin
            stb_q   <= 1'b0;
            ready_q <= 1'b1;
            if (!req_q.we) begin
              rdat_q <= master_dat_i;
            end
            state_q <= ST_DONE;
          end else if (expired_s) begin
            stb_q     <= 1'b0;
            err_q     <= 1'b1;
            cause_q   <= ERR_TIMEOUT;
            err_adr_q <= req_q.adr;
            state_q   <= ST_ERR;
          end else begin
            state_q <= ST_REQ;
          end
        end
        ST_DONE, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          stb_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_dat_o    = rdat_q;
  assign cpu_ready_o  = ready_q;
  assign cpu_err_o    = err_q;
  assign cpu_busy_o   = busy_q;
  assign err_cause_o  = cause_q;
  assign err_adr_o    = err_adr_q;
  assign master_stb_o = stb_q;
  assign master_we_o  = req_q.we;
  assign master_adr_o = req_q.adr;
  assign master_dat_o = req_q.dat;

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed plan cases plus random
// transactions against an outcome-level reference model.
module tb_bus_master_port;

  localparam int T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic        cpu_ready_o, cpu_err_o, cpu_busy_o;
  logic [1:0]  err_cause_o;
  logic [31:0] err_adr_o;
  logic        master_stb_o, master_we_o;
  logic [31:0] master_adr_o, master_dat_o, master_dat_i;
  logic        master_ack_i, adr_err_i;

  int checks = 0;
  int errors = 0;

  logic [7:0]  slave_lat;
  logic        slave_aerr;
  logic [7:0]  slave_wait_q;

  logic [31:0] m_dat, m_err_adr;
  logic [1:0]  m_cause;

  bus_master_port #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_adr_i(cpu_adr_i),
    .cpu_dat_i(cpu_dat_i), .cpu_dat_o(cpu_dat_o), .cpu_ready_o(cpu_ready_o),
    .cpu_err_o(cpu_err_o), .cpu_busy_o(cpu_busy_o), .err_cause_o(err_cause_o),
    .err_adr_o(err_adr_o), .master_stb_o(master_stb_o), .master_we_o(master_we_o),
    .master_adr_o(master_adr_o), .master_dat_o(master_dat_o),
    .master_dat_i(master_dat_i), .master_ack_i(master_ack_i), .adr_err_i(adr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave: counts strobe cycles and acks combinationally in stb cycle slave_lat+1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) slave_wait_q <= 8'd0;
    else if (!master_stb_o) slave_wait_q <= 8'd0;
    else slave_wait_q <= slave_wait_q + 8'd1;
  end

  assign master_ack_i = master_stb_o && (slave_wait_q == slave_lat);
  assign adr_err_i    = master_stb_o && slave_aerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; outcome predicted from ack latency, decode error and timeout limit.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [31:0] rdata, input int lat, input logic aerr);
    int stb_n = 0, end_c = 0, exp_stb, c;
    logic got_r = 1'b0, got_e = 1'b0, both = 1'b0, stable = 1'b1, exp_r;
    logic [1:0] exp_cause = 2'b00, obs_cause = 2'b00;
    logic [31:0] obs_dat = 32'd0, obs_eadr = 32'd0;
    slave_lat = 8'(lat); slave_aerr = aerr; master_dat_i = rdata;
    cpu_we_i = we; cpu_adr_i = adr; cpu_dat_i = dat; cpu_req_i = 1'b1;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    m_cause = 2'b00;
    if (aerr) begin
      exp_r = 1'b0; exp_stb = 1; exp_cause = 2'b01;
    end else if (lat + 1 > T) begin
      exp_r = 1'b0; exp_stb = T; exp_cause = 2'b10;
    end else begin
      exp_r = 1'b1; exp_stb = lat + 1;
    end
    if (exp_r && !we) m_dat = rdata;
    if (!exp_r) begin m_err_adr = adr; m_cause = exp_cause; end
    c = 1;
    while (c <= 20 && !(got_r || got_e)) begin
      if (master_stb_o) begin
        stb_n++;
        if (master_adr_o !== adr || master_dat_o !== dat || master_we_o !== we) stable = 1'b0;
      end
      if (cpu_ready_o && cpu_err_o) both = 1'b1;
      if (cpu_ready_o || cpu_err_o) begin
        got_r = cpu_ready_o; got_e = cpu_err_o; end_c = c;
        obs_dat = cpu_dat_o; obs_cause = err_cause_o; obs_eadr = err_adr_o;
      end else begin
        @(posedge clk_i); #1;
      end
      c++;
    end
    check("stb_cycles", 32'(stb_n), 32'(exp_stb));
    check("done_cycle", 32'(end_c), 32'(exp_stb + 1));
    check("ready", 32'(got_r), 32'(exp_r));
    check("err", 32'(got_e), 32'(!exp_r));
    check("ready_err_overlap", 32'(both), 32'd0);
    check("bus_stable", 32'(stable), 32'd1);
    check("err_cause", 32'(obs_cause), 32'(m_cause));
    check("err_adr", obs_eadr, m_err_adr);
    check("cpu_dat", obs_dat, m_dat);
    @(posedge clk_i); #1;
    check("busy_after", 32'(cpu_busy_o), 32'd0);
  endtask

  initial begin
    logic [5:0] stb_pat, busy_pat;
    logic spurious;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = 32'd0; cpu_dat_i = 32'd0;
    master_dat_i = 32'd0; slave_lat = 8'd0; slave_aerr = 1'b0;
    m_dat = 32'd0; m_err_adr = 32'd0; m_cause = 2'b00;
    #12;
    check("rst_stb", 32'(master_stb_o), 32'd0);
    check("rst_busy", 32'(cpu_busy_o), 32'd0);
    check("rst_ready_err", 32'({cpu_ready_o, cpu_err_o}), 32'd0);
    check("rst_dat", cpu_dat_o, 32'd0);
    check("rst_bus", master_adr_o | master_dat_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i);

    run_txn(1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 32'hCAFE_F00D, 3, 1'b0);
    run_txn(1'b0, 32'h0000_2000, 32'h0, 32'h1111_2222, 0, 1'b1);
    run_txn(1'b0, 32'h0000_3000, 32'h0, 32'h3333_4444, 4, 1'b0);
    run_txn(1'b0, 32'h0000_4000, 32'h0, 32'h5555_6666, 3, 1'b0);
    run_txn(1'b1, 32'h0000_5000, 32'hAAAA_5555, 32'h7777_8888, 9, 1'b0);

    // Back-to-back with combinational ack: accepts at cycles 0 and 3 only.
    @(negedge clk_i);
    slave_lat = 8'd0; slave_aerr = 1'b0; master_dat_i = 32'h0BAD_F00D;
    cpu_we_i = 1'b0; cpu_adr_i = 32'h0000_6000; cpu_req_i = 1'b1;
    @(posedge clk_i); #1;
    for (int c = 1; c <= 6; c++) begin
      stb_pat[c-1] = master_stb_o; busy_pat[c-1] = cpu_busy_o;
      if (c == 6) cpu_req_i = 1'b0;
      @(posedge clk_i); #1;
    end
    m_dat = 32'h0BAD_F00D; m_cause = 2'b00;
    check("b2b_stb", 32'(stb_pat), 32'h09);
    check("b2b_busy", 32'(busy_pat), 32'h1B);
    check("b2b_dat", cpu_dat_o, m_dat);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 6)), ($urandom_range(0, 5) == 0));
    end

    // Reset in the middle of a pending transaction.
    @(negedge clk_i);
    slave_lat = 8'd100; slave_aerr = 1'b0;
    cpu_we_i = 1'b0; cpu_adr_i = 32'h0000_7000; cpu_req_i = 1'b1;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    m_dat = 32'd0; m_err_adr = 32'd0; m_cause = 2'b00;
    check("midrst_stb", 32'(master_stb_o), 32'd0);
    check("midrst_busy", 32'(cpu_busy_o), 32'd0);
    check("midrst_cause", 32'(err_cause_o), 32'(m_cause));
    check("midrst_eadr", err_adr_o, m_err_adr);
    check("midrst_dat", cpu_dat_o, m_dat);
    @(negedge clk_i); rst_i = 1'b1;
    spurious = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      if (cpu_ready_o || cpu_err_o || master_stb_o) spurious = 1'b1;
    end
    check("midrst_no_pulse", 32'(spurious), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
